// File: rtl/hub75_scan_if.sv
// Framebuffer read port and HUB75 panel pins for the scan engine.
// The master side is the scanner; the slave side is the framebuffer and panel.
interface hub75_scan_if;
  logic [5:0]  fb_col;
  logic [63:0] fb_data;
  logic        r1;
  logic        r2;
  logic        sclk;
  logic        lat;
  logic        oe_n;
  logic [4:0]  addr;

  modport master (
    output fb_col, r1, r2, sclk, lat, oe_n, addr,
    input  fb_data
  );

  modport slave (
    input  fb_col, r1, r2, sclk, lat, oe_n, addr,
    output fb_data
  );
endinterface

// File: rtl/hub75_scan.sv
// 1/32-scan HUB75 driver: shifts one 64-column row pair from a column-major
// 64x64 framebuffer, blanks, latches and displays it, then moves to the next row.
module hub75_scan #(
  parameter int SCLK_DIV  = 1,
  parameter int ON_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  output logic         frame_start,
  hub75_scan_if.master panel
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREFETCH = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] BLANK    = 3'd4;
  localparam logic [2:0] LATCH    = 3'd5;
  localparam logic [2:0] DISPLAY  = 3'd6;

  localparam logic [3:0]  DIV_LAST = 4'(SCLK_DIV - 1);
  localparam logic [11:0] ON_LAST  = 12'(ON_CYCLES - 1);

  logic [2:0]  state;
  logic [4:0]  row;
  logic [5:0]  x;
  logic [3:0]  div_cnt;
  logic [11:0] on_cnt;

  logic [5:0]  fb_col_q;
  logic        r1_q;
  logic        r2_q;
  logic        sclk_q;
  logic        lat_q;
  logic        oe_n_q;
  logic [4:0]  addr_q;
  logic        frame_start_q;

  // Row a sits at bit a of the column word, row a+32 at bit a+32.
  logic top_bit;
  logic bot_bit;
  assign top_bit = panel.fb_data[{1'b0, row}];
  assign bot_bit = panel.fb_data[{1'b1, row}];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      row           <= 5'd0;
      x             <= 6'd0;
      div_cnt       <= 4'd0;
      on_cnt        <= 12'd0;
      fb_col_q      <= 6'd0;
      r1_q          <= 1'b0;
      r2_q          <= 1'b0;
      sclk_q        <= 1'b0;
      lat_q         <= 1'b0;
      oe_n_q        <= 1'b1;
      addr_q        <= 5'd0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      lat_q         <= 1'b0;
      case (state)
        IDLE: begin
          oe_n_q <= 1'b1;
          sclk_q <= 1'b0;
          if (enable) begin
            state         <= PREFETCH;
            row           <= 5'd0;
            x             <= 6'd0;
            fb_col_q      <= 6'd0;
            frame_start_q <= 1'b1;
          end
        end
        PREFETCH: begin
          state   <= SHIFT_LO;
          sclk_q  <= 1'b0;
          r1_q    <= top_bit;
          r2_q    <= bot_bit;
          div_cnt <= DIV_LAST;
        end
        SHIFT_LO: begin
          if (div_cnt == 4'd0) begin
            // Request the next column now so its word is ready by the next sample.
            state    <= SHIFT_HI;
            sclk_q   <= 1'b1;
            fb_col_q <= x + 6'd1;
            div_cnt  <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - 4'd1;
          end
        end
        SHIFT_HI: begin
          if (div_cnt == 4'd0) begin
            sclk_q <= 1'b0;
            if (x == 6'd63) begin
              state  <= BLANK;
              oe_n_q <= 1'b1;
              addr_q <= row;
            end else begin
              state   <= SHIFT_LO;
              x       <= x + 6'd1;
              r1_q    <= top_bit;
              r2_q    <= bot_bit;
              div_cnt <= DIV_LAST;
            end
          end else begin
            div_cnt <= div_cnt - 4'd1;
          end
        end
        BLANK: begin
          state <= LATCH;
          lat_q <= 1'b1;
        end
        LATCH: begin
          state  <= DISPLAY;
          oe_n_q <= 1'b0;
          on_cnt <= ON_LAST;
        end
        DISPLAY: begin
          if (on_cnt == 12'd0) begin
            oe_n_q <= 1'b1;
            if (enable) begin
              state         <= PREFETCH;
              row           <= row + 5'd1;
              x             <= 6'd0;
              fb_col_q      <= 6'd0;
              frame_start_q <= (row == 5'd31);
            end else begin
              state <= IDLE;
              row   <= 5'd0;
            end
          end else begin
            on_cnt <= on_cnt - 12'd1;
          end
        end
        default: begin
          state  <= IDLE;
          oe_n_q <= 1'b1;
          sclk_q <= 1'b0;
        end
      endcase
    end
  end

  assign panel.fb_col = fb_col_q;
  assign panel.r1     = r1_q;
  assign panel.r2     = r2_q;
  assign panel.sclk   = sclk_q;
  assign panel.lat    = lat_q;
  assign panel.oe_n   = oe_n_q;
  assign panel.addr   = addr_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_hub75_scan.sv
// Bench for hub75_scan: a default instance and an SCLK_DIV=3 instance share
// one clock and reset; panel activity is recorded line by line and compared to a framebuffer model.
module tb_hub75_scan;

  logic clk;
  logic reset;
  logic en1;
  logic en3;
  logic fs1;
  logic fs3;
  int   msel;
  int   n_checks;
  int   n_fail;

  logic [63:0] mem [64];

  hub75_scan_if bus1 ();
  hub75_scan_if bus3 ();

  assign bus1.fb_data = mem[bus1.fb_col];
  assign bus3.fb_data = mem[bus3.fb_col];

  hub75_scan u1 (
    .clk(clk), .reset(reset), .enable(en1), .frame_start(fs1), .panel(bus1)
  );

  hub75_scan #(.SCLK_DIV(3), .ON_CYCLES(64)) u3 (
    .clk(clk), .reset(reset), .enable(en3), .frame_start(fs3), .panel(bus3)
  );

  logic       m_sclk, m_lat, m_oe_n, m_r1, m_r2, m_fs;
  logic [4:0] m_addr;
  assign m_sclk = (msel == 1) ? bus3.sclk : bus1.sclk;
  assign m_lat  = (msel == 1) ? bus3.lat  : bus1.lat;
  assign m_oe_n = (msel == 1) ? bus3.oe_n : bus1.oe_n;
  assign m_r1   = (msel == 1) ? bus3.r1   : bus1.r1;
  assign m_r2   = (msel == 1) ? bus3.r2   : bus1.r2;
  assign m_fs   = (msel == 1) ? fs3       : fs1;
  assign m_addr = (msel == 1) ? bus3.addr : bus1.addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-line records gathered by watch()
  int          nl;
  int          l_rises [100];
  logic [63:0] l_top   [100];
  logic [63:0] l_bot   [100];
  int          l_addr  [100];
  int          l_pre1  [100];
  int          l_pre2  [100];
  int          l_cyc   [100];
  int          l_latw  [100];
  int          l_oerun [100];
  int          n_fs;
  int          fs_cyc  [100];
  int          hazards;
  int          addr_bad;
  int          phase_bad;
  int          rises_total;
  int          last_rise;
  logic        final_oe_n;

  function automatic logic [63:0] exp_line(input int a, input bit bottom);
    logic [63:0] v;
    int r;
    r = bottom ? a + 32 : a;
    for (int c = 0; c < 64; c++) v[c] = mem[c][r];
    return v;
  endfunction

  task automatic fill_random();
    for (int c = 0; c < 64; c++) mem[c] = {$urandom, $urandom};
  endtask

  task automatic fill_zero();
    for (int c = 0; c < 64; c++) mem[c] = 64'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en1   = 1'b0;
    en3   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic watch(input int sel, input int ncyc, input int drop);
    int div, cur_rises, run, latw, oerun;
    logic [63:0] cur_top, cur_bot;
    logic sclk_h1, lat_h1, oe_h1;
    logic [4:0] a_h1, a_h2;
    msel = sel;
    div = (sel == 1) ? 3 : 1;
    nl = 0; n_fs = 0; hazards = 0; addr_bad = 0; phase_bad = 0;
    rises_total = 0; last_rise = -1;
    cur_rises = 0; run = 0; latw = 0; oerun = 0;
    cur_top = '0; cur_bot = '0;
    sclk_h1 = 1'b0; lat_h1 = 1'b0; oe_h1 = 1'b1; a_h1 = 5'd0; a_h2 = 5'd0;
    for (int k = 0; k < 100; k++) begin
      l_latw[k] = -1; l_oerun[k] = -1; l_rises[k] = -1;
    end
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (m_fs && n_fs < 100) begin fs_cyc[n_fs] = i; n_fs++; end
      if (!m_oe_n && (m_sclk || m_lat)) hazards++;
      if (m_addr != a_h1 && (!m_oe_n || !oe_h1)) addr_bad++;
      if (m_sclk && !sclk_h1) begin
        if (cur_rises > 0 && run != div) phase_bad++;
        if (cur_rises < 64) begin
          cur_top[cur_rises] = m_r1;
          cur_bot[cur_rises] = m_r2;
        end
        cur_rises++; rises_total++; last_rise = i; run = 1;
      end else if (!m_sclk && sclk_h1) begin
        if (run != div) phase_bad++;
        run = 1;
      end else begin
        run++;
      end
      if (m_lat && !lat_h1) begin
        if (nl < 100) begin
          l_addr[nl] = m_addr; l_pre1[nl] = a_h1; l_pre2[nl] = a_h2;
          l_rises[nl] = cur_rises; l_top[nl] = cur_top; l_bot[nl] = cur_bot;
          l_cyc[nl] = i;
          nl++;
        end
        cur_rises = 0; cur_top = '0; cur_bot = '0; latw = 1;
      end else if (m_lat) begin
        latw++;
      end else if (lat_h1 && nl > 0) begin
        l_latw[nl-1] = latw;
      end
      if (!m_oe_n) oerun++;
      else if (!oe_h1) begin
        if (nl > 0) l_oerun[nl-1] = oerun;
        oerun = 0;
      end
      if (drop >= 0 && nl == drop && cur_rises == 10) begin
        if (sel == 1) en3 = 1'b0; else en1 = 1'b0;
      end
      a_h2 = a_h1; a_h1 = m_addr;
      sclk_h1 = m_sclk; lat_h1 = m_lat; oe_h1 = m_oe_n;
    end
    final_oe_n = m_oe_n;
  endtask

  task automatic test_reset();
    int lats;
    bit found;
    logic [4:0] addr_before;
    msel = 0;
    fill_random();
    @(negedge clk);
    reset = 1'b0; en1 = 1'b0; en3 = 1'b0;
    #1;
    n_checks++;
    if ({bus1.fb_col, bus1.r1, bus1.r2, bus1.sclk, bus1.lat, bus1.oe_n, bus1.addr, fs1}
        !== {6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got col=%0d r1=%b r2=%b sclk=%b lat=%b oe_n=%b addr=%0d fs=%b, expected all 0 except oe_n=1",
               bus1.fb_col, bus1.r1, bus1.r2, bus1.sclk, bus1.lat, bus1.oe_n, bus1.addr, fs1);
    end
    @(negedge clk);
    reset = 1'b1; en1 = 1'b1;
    lats = 0; found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus1.lat) lats++;
      if (lats >= 2 && bus1.sclk) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_reach_shift_hi: got timeout, expected sclk high on line 2");
    end
    addr_before = bus1.addr;
    n_checks++;
    if (addr_before !== 5'd1) begin
      n_fail++;
      $display("FAIL addr_before_reset: got %0d expected 1", addr_before);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus1.fb_col, bus1.r1, bus1.r2, bus1.sclk, bus1.lat, bus1.oe_n, bus1.addr, fs1}
        !== {6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_midline: got col=%0d sclk=%b lat=%b oe_n=%b addr=%0d, expected col=0 sclk=0 lat=0 oe_n=1 addr=0",
               bus1.fb_col, bus1.sclk, bus1.lat, bus1.oe_n, bus1.addr);
    end
    @(negedge clk);
    reset = 1'b1;
    watch(0, 2 * 195 + 5, -1);
    n_checks++;
    if (n_fs < 1 || fs_cyc[0] != 0) begin
      n_fail++;
      $display("FAIL restart_frame_start: got count=%0d first=%0d expected first at 0", n_fs, fs_cyc[0]);
    end
    n_checks++;
    if (nl < 1 || l_addr[0] != 0 || l_rises[0] != 64) begin
      n_fail++;
      $display("FAIL restart_row0: got lines=%0d addr=%0d rises=%0d expected addr 0 with 64 rises", nl, l_addr[0], l_rises[0]);
    end
    n_checks++;
    if (l_top[0] !== exp_line(0, 0) || l_bot[0] !== exp_line(0, 1)) begin
      n_fail++;
      $display("FAIL restart_row0_data: got top=%h bot=%h expected top=%h bot=%h",
               l_top[0], l_bot[0], exp_line(0, 0), exp_line(0, 1));
    end
  endtask

  task automatic test_top_pixel();
    fill_zero();
    mem[5][3] = 1'b1;
    do_reset();
    en1 = 1'b1;
    watch(0, 32 * 195 + 5, -1);
    n_checks++;
    if (nl != 32) begin
      n_fail++;
      $display("FAIL top_line_count: got %0d expected 32", nl);
    end
    for (int l = 0; l < nl && l < 32; l++) begin
      n_checks++;
      if (l_top[l] !== exp_line(l, 0) || l_bot[l] !== 64'd0) begin
        n_fail++;
        $display("FAIL top_pixel_line%0d: got top=%h bot=%h expected top=%h bot=0", l, l_top[l], l_bot[l], exp_line(l, 0));
      end
    end
    n_checks++;
    if (nl > 3 && l_top[3] !== 64'h0000_0000_0000_0020) begin
      n_fail++;
      $display("FAIL top_pixel_col5: got %h expected 0000000000000020", l_top[3]);
    end
  endtask

  task automatic test_bottom_pixel();
    fill_zero();
    mem[63][35] = 1'b1;
    do_reset();
    en1 = 1'b1;
    watch(0, 32 * 195 + 5, -1);
    for (int l = 0; l < nl && l < 32; l++) begin
      n_checks++;
      if (l_bot[l] !== exp_line(l, 1) || l_top[l] !== 64'd0) begin
        n_fail++;
        $display("FAIL bottom_pixel_line%0d: got top=%h bot=%h expected top=0 bot=%h", l, l_top[l], l_bot[l], exp_line(l, 1));
      end
    end
    n_checks++;
    if (nl < 4 || l_bot[3] !== 64'h8000_0000_0000_0000) begin
      n_fail++;
      $display("FAIL bottom_pixel_col63: got %h expected 8000000000000000", l_bot[3]);
    end
  endtask

  task automatic test_framing();
    fill_random();
    do_reset();
    en1 = 1'b1;
    watch(0, 6 * 195 + 5, -1);
    n_checks++;
    if (nl != 6 || l_cyc[0] != 130) begin
      n_fail++;
      $display("FAIL framing_first_latch: got lines=%0d lat_cycle=%0d expected 6 lines, lat at 130", nl, l_cyc[0]);
    end
    for (int l = 0; l < nl && l < 6; l++) begin
      n_checks++;
      if (l_rises[l] != 64 || l_latw[l] != 1 || l_oerun[l] != 64 || l_addr[l] != l || l_pre1[l] != l) begin
        n_fail++;
        $display("FAIL framing_line%0d: got rises=%0d latw=%0d oe_low=%0d addr=%0d addr_pre=%0d expected 64/1/64/%0d/%0d",
                 l, l_rises[l], l_latw[l], l_oerun[l], l_addr[l], l_pre1[l], l, l);
      end
      if (l > 0) begin
        n_checks++;
        if (l_cyc[l] - l_cyc[l-1] != 195 || l_pre2[l] != l - 1) begin
          n_fail++;
          $display("FAIL framing_period%0d: got period=%0d addr_before_blank=%0d expected 195 and %0d",
                   l, l_cyc[l] - l_cyc[l-1], l_pre2[l], l - 1);
        end
      end
      n_checks++;
      if (l_top[l] !== exp_line(l, 0) || l_bot[l] !== exp_line(l, 1)) begin
        n_fail++;
        $display("FAIL framing_data%0d: got top=%h bot=%h expected top=%h bot=%h",
                 l, l_top[l], l_bot[l], exp_line(l, 0), exp_line(l, 1));
      end
    end
    n_checks++;
    if (hazards != 0 || addr_bad != 0) begin
      n_fail++;
      $display("FAIL framing_oe_overlap: got hazards=%0d addr_changes_lit=%0d expected 0 and 0", hazards, addr_bad);
    end
  endtask

  task automatic test_wrap();
    int bad;
    fill_random();
    do_reset();
    en1 = 1'b1;
    watch(0, 2 * 6240 + 200, -1);
    n_checks++;
    if (nl != 65) begin
      n_fail++;
      $display("FAIL wrap_line_count: got %0d expected 65", nl);
    end
    bad = 0;
    for (int l = 0; l < nl; l++) begin
      n_checks++;
      if (l_addr[l] != l % 32 || l_top[l] !== exp_line(l % 32, 0) || l_bot[l] !== exp_line(l % 32, 1)) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL wrap_line%0d: got addr=%0d top=%h bot=%h expected addr=%0d top=%h bot=%h",
                   l, l_addr[l], l_top[l], l_bot[l], l % 32, exp_line(l % 32, 0), exp_line(l % 32, 1));
      end
    end
    n_checks++;
    if (n_fs != 3) begin
      n_fail++;
      $display("FAIL wrap_frame_count: got %0d expected 3", n_fs);
    end
    for (int k = 0; k < n_fs && k < 3; k++) begin
      n_checks++;
      if (fs_cyc[k] != 6240 * k) begin
        n_fail++;
        $display("FAIL wrap_frame_start%0d: got cycle %0d expected %0d", k, fs_cyc[k], 6240 * k);
      end
    end
    n_checks++;
    if (hazards != 0 || addr_bad != 0) begin
      n_fail++;
      $display("FAIL wrap_oe_overlap: got hazards=%0d addr_changes_lit=%0d expected 0 and 0", hazards, addr_bad);
    end
  endtask

  task automatic test_enable_drop(input int sel);
    int div, period;
    div = (sel == 1) ? 3 : 1;
    period = 1 + 128 * div + 2 + 64;
    fill_random();
    do_reset();
    if (sel == 1) en3 = 1'b1; else en1 = 1'b1;
    watch(sel, 8 * period + 600, 7);
    n_checks++;
    if (nl != 8 || rises_total != 512 || n_fs != 1) begin
      n_fail++;
      $display("FAIL drop_div%0d_counts: got lines=%0d rises=%0d frame_starts=%0d expected 8/512/1",
               div, nl, rises_total, n_fs);
    end
    n_checks++;
    if (nl < 8 || l_addr[7] != 7 || l_oerun[7] != 64 || last_rise >= l_cyc[7] || final_oe_n !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_div%0d_line7: got addr=%0d oe_low=%0d last_rise=%0d lat=%0d oe_n_end=%b expected 7/64/before lat/1",
               div, l_addr[7], l_oerun[7], last_rise, l_cyc[7], final_oe_n);
    end
    n_checks++;
    if (l_cyc[0] != 1 + 128 * div + 1) begin
      n_fail++;
      $display("FAIL drop_div%0d_first_latch: got %0d expected %0d", div, l_cyc[0], 1 + 128 * div + 1);
    end
    for (int l = 1; l < nl && l < 8; l++) begin
      n_checks++;
      if (l_cyc[l] - l_cyc[l-1] != period) begin
        n_fail++;
        $display("FAIL drop_div%0d_period%0d: got %0d expected %0d", div, l, l_cyc[l] - l_cyc[l-1], period);
      end
    end
    for (int l = 0; l < nl && l < 8; l++) begin
      n_checks++;
      if (l_top[l] !== exp_line(l, 0) || l_bot[l] !== exp_line(l, 1)) begin
        n_fail++;
        $display("FAIL drop_div%0d_data%0d: got top=%h bot=%h expected top=%h bot=%h",
                 div, l, l_top[l], l_bot[l], exp_line(l, 0), exp_line(l, 1));
      end
    end
    n_checks++;
    if (phase_bad != 0 || hazards != 0) begin
      n_fail++;
      $display("FAIL drop_div%0d_phases: got bad_phases=%0d hazards=%0d expected 0 and 0", div, phase_bad, hazards);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    msel     = 0;
    reset    = 1'b0;
    en1      = 1'b0;
    en3      = 1'b0;
    fill_zero();
    test_reset();
    test_top_pixel();
    test_bottom_pixel();
    test_framing();
    test_wrap();
    test_enable_drop(0);
    test_enable_drop(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
